// File: rtl/synapse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synapse_pkg
// Description : Shared types and helpers for the time-multiplexed synapse
//               scheduler: FSM state encoding, default widths, accumulator
//               width formula and the accumulator-to-output saturation.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package synapse_pkg;

  // Default geometry of one scheduler instance.
  localparam int SYN_DATA_W   = 8;
  localparam int SYN_N_INPUTS = 4;

  // Widest accumulator the saturation helpers accept.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Sum of N products of two data_w-bit operands needs 2*data_w bits plus
  // one bit per doubling of N, so this width can never overflow.
  function automatic int acc_width(input int data_w, input int idx_w);
    return 2 * data_w + idx_w;
  endfunction

  localparam int SYN_ACC_W = acc_width(SYN_DATA_W, $clog2(SYN_N_INPUTS));

  // Largest value representable in data_w bits.
  function automatic logic [SAT_MAX_W-1:0] max_of(input int unsigned data_w);
    return (SAT_MAX_W'(1) << data_w) - SAT_MAX_W'(1);
  endfunction

  // True when the accumulator does not fit in data_w bits.
  function automatic logic overflows(input logic [SAT_MAX_W-1:0] acc,
                                     input int unsigned          data_w);
    return acc > max_of(data_w);
  endfunction

  // Clamp the accumulator to all-ones of data_w bits; caller keeps the low
  // data_w bits of the result.
  function automatic logic [SAT_MAX_W-1:0] saturate(input logic [SAT_MAX_W-1:0] acc,
                                                     input int unsigned          data_w);
    return overflows(acc, data_w) ? max_of(data_w) : acc;
  endfunction

endpackage : synapse_pkg
`default_nettype wire

// File: rtl/synapse_weight_rf.sv
`default_nettype none
// ============================================================================
// Module      : synapse_weight_rf
// Description : N_INPUTS x DATA_W weight register file. One synchronous write
//               port, one combinational read port. A write and a read of the
//               same entry in one cycle returns the old weight.
// Ports       : clk_i, rst_i (async, active-high, clears all weights)
//               we_i / waddr_i / wdata_i : write port (out-of-range ignored)
//               raddr_i / rdata_o         : combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_weight_rf #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] weights [N_INPUTS];

  // Only matters when N_INPUTS is not a power of two: addresses that the
  // port can express but that have no entry are dropped.
  logic addr_in_range;
  assign addr_in_range = ({1'b0, waddr_i} < (IDX_W+1)'(N_INPUTS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        weights[k] <= '0;
      end
    end else if (we_i && addr_in_range) begin
      weights[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = weights[raddr_i];

endmodule : synapse_weight_rf
`default_nettype wire

// File: rtl/synapse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : synapse_scheduler
// Description : Shares one registered DATA_W x DATA_W multiplier across
//               N_INPUTS input/weight pairs. Accepts a packed input vector,
//               multiplies each element by its stored weight one per cycle,
//               accumulates, and presents a saturated DATA_W-bit sum.
// Ports       : clk_i, rst_i            : clock, async active-high reset
//               weight_we_i/addr_i/data_i : weight register file write port
//               in_valid_i/in_ready_o/in_data_i : input vector handshake
//               out_valid_o/out_ready_i/out_data_o/out_sat_o : result handshake
//               busy_o                   : FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_scheduler
  import synapse_pkg::*;
#(
  parameter int N_INPUTS = SYN_N_INPUTS,
  parameter int DATA_W   = SYN_DATA_W,
  parameter int IDX_W    = $clog2(N_INPUTS),
  parameter int ACC_W    = acc_width(DATA_W, IDX_W)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       weight_we_i,
  input  logic [IDX_W-1:0]           weight_addr_i,
  input  logic [DATA_W-1:0]          weight_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [N_INPUTS*DATA_W-1:0] in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_sat_o,
  output logic                       busy_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  state_t                    state;
  logic [N_INPUTS*DATA_W-1:0] data_vec;
  logic [IDX_W-1:0]          idx;
  logic [2*DATA_W-1:0]       prod;
  logic [ACC_W-1:0]          acc;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_sat;

  logic [DATA_W-1:0]         cur_data;
  logic [DATA_W-1:0]         cur_weight;
  logic [2*DATA_W-1:0]       prod_next;
  logic [ACC_W-1:0]          acc_sum;
  logic [SAT_MAX_W-1:0]      acc_wide;
  logic [SAT_MAX_W-1:0]      sat_wide;
  logic                      acc_over;

  // Weights are read live: the entry for idx is whatever the register file
  // holds in the cycle that index is multiplied.
  synapse_weight_rf #(
    .N_INPUTS (N_INPUTS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_weight_rf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (weight_we_i),
    .waddr_i (weight_addr_i),
    .wdata_i (weight_data_i),
    .raddr_i (idx),
    .rdata_o (cur_weight)
  );

  assign cur_data  = data_vec[idx*DATA_W +: DATA_W];
  assign prod_next = (2*DATA_W)'(cur_data) * (2*DATA_W)'(cur_weight);
  assign acc_sum   = acc + ACC_W'(prod);

  assign acc_wide  = SAT_MAX_W'(acc_sum);
  assign sat_wide  = saturate(acc_wide, DATA_W);
  assign acc_over  = overflows(acc_wide, DATA_W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      data_vec  <= '0;
      idx       <= '0;
      prod      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            data_vec <= in_data_i;
            acc      <= '0;
            idx      <= '0;
            state    <= ST_MUL;
          end
        end

        ST_MUL: begin
          prod <= prod_next;
          // The product register is empty during the first MUL cycle.
          if (idx != '0) begin
            acc <= acc_sum;
          end
          if (idx == IDX_LAST) begin
            state <= ST_DRAIN;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        ST_DRAIN: begin
          // Fold in the final product and capture the result in one step so
          // the output is ready the same edge out_valid rises.
          acc       <= acc_sum;
          out_data  <= sat_wide[DATA_W-1:0];
          out_sat   <= acc_over;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready_i) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst_i so no upstream transfer appears to complete during reset.
  assign in_ready_o  = (state == ST_IDLE) && !rst_i;
  assign busy_o      = (state != ST_IDLE);
  assign out_valid_o = out_valid;
  assign out_data_o  = out_data;
  assign out_sat_o   = out_sat;

endmodule : synapse_scheduler
`default_nettype wire

// File: doc/synapse_scheduler.md
Name: synapse_scheduler

Overview:
- Time-multiplexes one registered 8x8 multiply stage across N_INPUTS input/weight pairs feeding a single neuron.
- Holds a small weight register file, accepts one input vector per valid/ready handshake, multiplies and accumulates the N weighted terms, then presents a saturated 8-bit sum to the downstream neuron.
- Sits between the spike/data source and the neuron, replacing N parallel synapse multipliers.

Parameters:
- N_INPUTS, 4, number of input/weight pairs per vector (>=2).
- DATA_W, 8, width of each data element, weight and output.
- IDX_W, $clog2(N_INPUTS), width of index and weight address (derived).
- ACC_W, 2*DATA_W+IDX_W, accumulator width (derived; cannot overflow).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- weight_we_i  in  1  weight write strobe.
- weight_addr_i  in  IDX_W  weight index to write.
- weight_data_i  in  DATA_W  weight value (unsigned).
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  scheduler can accept a vector.
- in_data_i  in  N_INPUTS*DATA_W  packed vector; element k is bits [k*DATA_W +: DATA_W].
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- out_data_o  out  DATA_W  saturated weighted sum.
- out_sat_o  out  1  sum exceeded 2^DATA_W-1; qualified by out_valid_o.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async, while rst_i=1): state=IDLE, all weights=0, acc=0, prod=0, idx=0, out_valid_o=0, out_data_o=0, out_sat_o=0, busy_o=0. in_ready_o is forced to 0 while rst_i=1.
- Arithmetic: all values unsigned. prod = data[idx]*w[idx] is 2*DATA_W wide. acc is ACC_W wide. out_data_o = (acc > 2^DATA_W-1) ? all-ones : acc[DATA_W-1:0]. out_sat_o is the same comparison.
- Weight writes:
  - Take effect at the clock edge when weight_we_i=1, in any state.
  - addr >= N_INPUTS is ignored.
  - Weights are read live at the cycle their index is multiplied. A write during MUL to an index not yet read affects the current result; a write to an index already read does not.
- FSM states IDLE, MUL, DRAIN, OUT.
  - IDLE: in_ready_o=1. On in_valid_i & in_ready_o at edge T: latch in_data_i into an internal vector, acc<=0, idx<=0, go to MUL. Input may change after T.
  - MUL: each edge, prod<=data[idx]*w[idx]. From the second MUL cycle on, acc<=acc+prod. idx increments. When idx==N_INPUTS-1, go to DRAIN.
  - DRAIN: acc<=acc+prod (last term), go to OUT.
  - OUT: out_valid_o=1, with out_data_o and out_sat_o held stable. On out_ready_i=1 at an edge: out_valid_o<=0 and go to IDLE. Stalls indefinitely otherwise.
- Latency: out_valid_o rises N_INPUTS+1 cycles after the accept edge (5 for N=4). Minimum accept-to-accept interval is N_INPUTS+3 cycles.
- Simultaneous events:
  - in_valid_i is ignored outside IDLE.
  - out_ready_i is ignored outside OUT.
  - A weight write and a read of the same index in the same cycle uses the old weight.
- Reset asserted mid-operation: immediately abandons the vector, returns everything to reset values and clears weights. No output is produced for the abandoned vector.
- out_data_o keeps its last value after the handshake until the next DRAIN→OUT transition.

Decomposition:
- synapse_pkg holds:
  - the state enum (IDLE, MUL, DRAIN, OUT);
  - width constants DATA_W and the ACC_W formula;
  - a saturate function (ACC_W to DATA_W).
- One natural sub-module, synapse_weight_rf: an N_INPUTS x DATA_W register file with async reset, one write port and one combinational read port indexed by idx.
- FSM, multiply stage and accumulator stay in the top.

Test Plan:
- Reset then idle: assert rst_i mid-cycle → outputs 0 and in_ready_o=0 immediately; after release, in_ready_o=1 and busy_o=0.
- Basic sum: weights {1,2,3,4}, data {10,20,30,40}, out_ready_i=1 → out_valid_o exactly 5 cycles after accept, out_data_o=300-255→saturated 255 with out_sat_o=1. Repeat with data {1,2,3,4} → out_data_o=30, out_sat_o=0.
- Backpressure: out_ready_i=0 for 10 cycles → out_valid_o and out_data_o held stable and in_ready_o=0 throughout; a new in_valid_i is ignored. Raise out_ready_i → IDLE, then accept the next vector.
- Weight boundaries: write addr 3=255, data {0,0,0,255} → out_sat_o=1, out_data_o=255. Write to addr 5 with N=4 → no weight changes (read back via the result).
- Mid-compute weight write: during MUL idx=1, write w[3]=0 and w[0]=9 → result uses the new w[3] and the old w[0].
- Reset mid-operation: assert rst_i in DRAIN → no out_valid_o. After release, weights read 0 and data {5,5,5,5} gives out_data_o=0.
